// File: rtl/ifsram_read_gen_pkg.sv
// Shared ifmap SRAM geometry and read-FSM state encodings (also used by the fill side).
package ifsram_read_gen_pkg;

    localparam int IFMAP_SRAM_ADDBITS    = 11;
    localparam int IFMAP_SRAM_DATA_WIDTH = 64;
    localparam int IF_READ_LEN_BITS      = 12;
    localparam int IF_READ_FIFO_DEPTH    = 2;

    typedef enum logic [1:0] {
        IF_ST_IDLE  = 2'd0,
        IF_ST_READ  = 2'd1,
        IF_ST_DRAIN = 2'd2,
        IF_ST_DONE  = 2'd3
    } if_state_e;

endpackage

// File: rtl/if_read_fifo2.sv
// 2-entry register FIFO; head is a register output, 0 cycles push-to-head visibility after edge.
// Push into a full FIFO is only taken together with a pop; pop on empty is ignored.
module if_read_fifo2 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop_ok;
    logic             push_ok;
    logic [1:0]       count_d;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifsram_read_gen.sv
// Streams len words from the idle ifmap SRAM bank to the PE array; start->valid is 2 edges.
// PE backpressure is absorbed by a 2-word credit window (FIFO + in-flight read).
module ifsram_read_gen
    import ifsram_read_gen_pkg::*;
#(
    parameter int DATA_WIDTH = IFMAP_SRAM_DATA_WIDTH,
    parameter int ADDR_BITS  = IFMAP_SRAM_ADDBITS,
    parameter int LEN_BITS   = IF_READ_LEN_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_if_read,
    input  logic                  if_read_bank,
    input  logic [ADDR_BITS-1:0]  if_read_base_addr,
    input  logic [LEN_BITS-1:0]   if_read_len,
    output logic                  if_read_busy,
    output logic                  if_read_done,
    output logic                  cen_ifsram_b0,
    output logic                  cen_ifsram_b1,
    output logic                  wen_ifsram,
    output logic [ADDR_BITS-1:0]  addr_ifsram,
    input  logic [DATA_WIDTH-1:0] dout_sram_b0,
    input  logic [DATA_WIDTH-1:0] dout_sram_b1,
    output logic [DATA_WIDTH-1:0] pe_data_dout,
    output logic                  pe_valid_dout,
    input  logic                  pe_ready_din
);

    if_state_e             state_q, state_d;
    logic                  bank_q;
    logic [ADDR_BITS-1:0]  base_q;
    logic [LEN_BITS-1:0]   len_q;
    logic [LEN_BITS-1:0]   issued_q;
    logic                  inflight_q;

    logic [1:0]            fifo_cnt;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic [DATA_WIDTH-1:0] rd_dat;
    logic                  pop;
    logic                  issue;
    logic                  issue_last;
    logic                  drain_empty;
    logic                  accept;
    logic [2:0]            owned;

    assign pop   = pe_valid_dout && pe_ready_din;
    // Words the FIFO will still hold after this edge, counting the read whose data lands next edge.
    assign owned = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};

    assign accept      = (state_q == IF_ST_IDLE) && start_if_read;
    assign issue       = (state_q == IF_ST_READ) && (issued_q != len_q) && (owned < 3'd2);
    assign issue_last  = issue && ((issued_q + LEN_BITS'(1)) == len_q);
    assign drain_empty = !inflight_q && (fifo_cnt == (pop ? 2'd1 : 2'd0));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IF_ST_IDLE: begin
                if (start_if_read) begin
                    state_d = (if_read_len == '0) ? IF_ST_DONE : IF_ST_READ;
                end
            end
            IF_ST_READ: begin
                if (issue_last) begin
                    state_d = IF_ST_DRAIN;
                end
            end
            IF_ST_DRAIN: begin
                if (drain_empty) begin
                    state_d = IF_ST_DONE;
                end
            end
            IF_ST_DONE: begin
                state_d = IF_ST_IDLE;
            end
            default: begin
                state_d = IF_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IF_ST_IDLE;
            bank_q     <= 1'b0;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                bank_q   <= if_read_bank;
                base_q   <= if_read_base_addr;
                len_q    <= if_read_len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LEN_BITS'(1);
            end
        end
    end

    // Address wraps naturally at the bank size.
    assign addr_ifsram   = base_q + issued_q[ADDR_BITS-1:0];
    assign cen_ifsram_b0 = !(issue && !bank_q);
    assign cen_ifsram_b1 = !(issue && bank_q);
    assign wen_ifsram    = 1'b1;

    assign rd_dat = bank_q ? dout_sram_b1 : dout_sram_b0;

    if_read_fifo2 #(
        .WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_dat_i (rd_dat),
        .pop_i      (pop),
        .count_o    (fifo_cnt),
        .head_o     (fifo_head)
    );

    assign pe_valid_dout = (fifo_cnt != 2'd0);
    assign pe_data_dout  = fifo_head;
    assign if_read_busy  = (state_q != IF_ST_IDLE);
    assign if_read_done  = (state_q == IF_ST_DONE);

endmodule

// File: tb/tb_ifsram_read_gen.sv
// Directed bench for ifsram_read_gen: behavioural 1-cycle SRAMs, negedge drive/sample.
module tb_ifsram_read_gen;

    localparam int DW = 64;
    localparam int AW = 11;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_if_read;
    logic          if_read_bank;
    logic [AW-1:0] if_read_base_addr;
    logic [LW-1:0] if_read_len;
    logic          if_read_busy;
    logic          if_read_done;
    logic          cen_ifsram_b0;
    logic          cen_ifsram_b1;
    logic          wen_ifsram;
    logic [AW-1:0] addr_ifsram;
    logic [DW-1:0] dout_sram_b0;
    logic [DW-1:0] dout_sram_b1;
    logic [DW-1:0] pe_data_dout;
    logic          pe_valid_dout;
    logic          pe_ready_din;

    logic [DW-1:0] mem0 [0:2047];
    logic [DW-1:0] mem1 [0:2047];

    int checks = 0;
    int errors = 0;

    int r_pops, r_issues, r_done_cnt, r_done_cyc, r_first_vld, r_max_owned, r_wrong_cen, r_busy_cnt;
    bit r_timeout;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!cen_ifsram_b0) dout_sram_b0 <= mem0[addr_ifsram];
        if (!cen_ifsram_b1) dout_sram_b1 <= mem1[addr_ifsram];
    end

    ifsram_read_gen dut (
        .clk               (clk),
        .reset             (reset),
        .start_if_read     (start_if_read),
        .if_read_bank      (if_read_bank),
        .if_read_base_addr (if_read_base_addr),
        .if_read_len       (if_read_len),
        .if_read_busy      (if_read_busy),
        .if_read_done      (if_read_done),
        .cen_ifsram_b0     (cen_ifsram_b0),
        .cen_ifsram_b1     (cen_ifsram_b1),
        .wen_ifsram        (wen_ifsram),
        .addr_ifsram       (addr_ifsram),
        .dout_sram_b0      (dout_sram_b0),
        .dout_sram_b1      (dout_sram_b1),
        .pe_data_dout      (pe_data_dout),
        .pe_valid_dout     (pe_valid_dout),
        .pe_ready_din      (pe_ready_din)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_word(input logic bank, input logic [AW-1:0] a);
        return bank ? (64'hB000_0000 + 64'(a)) : (64'h100 + 64'(a));
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},  64'(if_read_busy),  64'd0);
        check({tag, "_done"},  64'(if_read_done),  64'd0);
        check({tag, "_cen0"},  64'(cen_ifsram_b0), 64'd1);
        check({tag, "_cen1"},  64'(cen_ifsram_b1), 64'd1);
        check({tag, "_wen"},   64'(wen_ifsram),    64'd1);
        check({tag, "_addr"},  64'(addr_ifsram),   64'd0);
        check({tag, "_valid"}, 64'(pe_valid_dout), 64'd0);
        check({tag, "_data"},  pe_data_dout,       64'd0);
    endtask

    // rmode 0: ready always 1; rmode 1: ready 1,0,1,0,... from the first cycle after start.
    task automatic run_xfer(input logic bank, input logic [AW-1:0] base, input logic [LW-1:0] len,
                            input int rmode, input int abort_after);
        logic [DW-1:0] prev_dat;
        logic [AW-1:0] a;
        bit            prev_stall;
        r_pops = 0; r_issues = 0; r_done_cnt = 0; r_done_cyc = 0;
        r_first_vld = 0; r_max_owned = 0; r_wrong_cen = 0; r_busy_cnt = 0;
        r_timeout = 1'b1;
        prev_stall = 1'b0;
        prev_dat = '0;
        @(negedge clk);
        start_if_read     = 1'b1;
        if_read_bank      = bank;
        if_read_base_addr = base;
        if_read_len       = len;
        @(negedge clk);
        start_if_read     = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge clk);
            pe_ready_din = (rmode == 0) ? 1'b1 : ((c % 2) == 1);
            #1;
            if (!if_read_busy) begin
                r_timeout = 1'b0;
                break;
            end
            r_busy_cnt++;
            if ((r_issues - r_pops) > r_max_owned) r_max_owned = r_issues - r_pops;
            if (prev_stall) check("stall_hold", pe_data_dout, prev_dat);
            if (!cen_ifsram_b0 || !cen_ifsram_b1) begin
                if ((bank ? cen_ifsram_b0 : cen_ifsram_b1) == 1'b0) r_wrong_cen++;
                a = base + r_issues[AW-1:0];
                check("addr", 64'(addr_ifsram), 64'(a));
                r_issues++;
            end
            if (if_read_done) begin
                r_done_cnt++;
                r_done_cyc = c;
            end
            if (pe_valid_dout && (r_first_vld == 0)) r_first_vld = c;
            prev_stall = pe_valid_dout && !pe_ready_din;
            prev_dat   = pe_data_dout;
            if (pe_valid_dout && pe_ready_din) begin
                a = base + r_pops[AW-1:0];
                check("data", pe_data_dout, exp_word(bank, a));
                r_pops++;
                if ((abort_after > 0) && (r_pops == abort_after)) begin
                    r_timeout = 1'b0;
                    break;
                end
            end
        end
        if (r_timeout) check("timeout", 64'd1, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 64'h100 + 64'(i);
            mem1[i] = 64'hB000_0000 + 64'(i);
        end
        dout_sram_b0      = '0;
        dout_sram_b1      = '0;
        reset             = 1'b0;
        start_if_read     = 1'b0;
        if_read_bank      = 1'b0;
        if_read_base_addr = '0;
        if_read_len       = '0;
        pe_ready_din      = 1'b0;

        // Reset state, while asserted and after release
        repeat (3) @(negedge clk);
        #1;
        check_reset_vals("rst_held");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("rst_rel");

        // bank0, base 0, len 4, ready 1
        run_xfer(1'b0, 11'd0, 12'd4, 0, 0);
        check("t2_words",     64'(r_pops),      64'd4);
        check("t2_first_vld", 64'(r_first_vld), 64'd3);
        check("t2_done_cnt",  64'(r_done_cnt),  64'd1);
        check("t2_done_cyc",  64'(r_done_cyc),  64'd7);
        check("t2_wrong_cen", 64'(r_wrong_cen), 64'd0);

        // bank1, base 16, len 8, alternating ready
        run_xfer(1'b1, 11'd16, 12'd8, 1, 0);
        check("t3_words",     64'(r_pops),      64'd8);
        check("t3_issues",    64'(r_issues),    64'd8);
        check("t3_done_cnt",  64'(r_done_cnt),  64'd1);
        check("t3_owned_le2", 64'(r_max_owned <= 2), 64'd1);
        check("t3_wrong_cen", 64'(r_wrong_cen), 64'd0);

        // address wrap 2046 -> 1
        run_xfer(1'b0, 11'd2046, 12'd4, 0, 0);
        check("t4_words",    64'(r_pops),     64'd4);
        check("t4_done_cnt", 64'(r_done_cnt), 64'd1);
        check("t4_done_cyc", 64'(r_done_cyc), 64'd7);

        // zero length
        run_xfer(1'b0, 11'd5, 12'd0, 0, 0);
        check("t5_issues",   64'(r_issues),   64'd0);
        check("t5_done_cnt", 64'(r_done_cnt), 64'd1);
        check("t5_done_cyc", 64'(r_done_cyc), 64'd1);
        check("t5_busy_cnt", 64'(r_busy_cnt), 64'd1);
        check("t5_words",    64'(r_pops),     64'd0);

        // reset mid-transfer after 10 words
        run_xfer(1'b1, 11'd100, 12'd32, 0, 10);
        check("t6_words_before", 64'(r_pops),     64'd10);
        check("t6_no_done",      64'(r_done_cnt), 64'd0);
        reset = 1'b0;
        #1;
        check_reset_vals("t6_rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_reset_vals("t6_rel");
        run_xfer(1'b0, 11'd40, 12'd2, 0, 0);
        check("t6_new_words", 64'(r_pops),     64'd2);
        check("t6_new_done",  64'(r_done_cnt), 64'd1);
        check("t6_new_cyc",   64'(r_done_cyc), 64'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
